instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage and producer side of the IF/ID pipeline register. It owns the PC, issues single-outstanding requests to instruction memory, and buffers each returned word with its PC. It presents each buffered word to the IF/ID register until that register's enable accepts it, and handles redirects (branch, jump, trap) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) driven whenever if_valid=0.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  request strobe; one cycle per request; memory always accepts.
imem_addr  out  `ADDR_WIDTH  request address (= pc_q), word-aligned.
imem_rvalid  in  1  response valid; at least 1 cycle after imem_req.
imem_rdata  in  `DATA_WIDTH  response instruction word.
if_id_en  in  1  IF/ID register enable from the hazard unit; 1 = downstream latches this cycle.
redirect_valid  in  1  redirect request from EX/branch unit.
redirect_pc  in  `ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
if_pc  out  `ADDR_WIDTH  PC of the buffered instruction.
if_instr  out  `DATA_WIDTH  buffered instruction, or NOP_INSTR when if_valid=0.
if_valid  out  1  buffered instruction present and not being killed.

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, pc_q=RESET_PC, kill=0.
  - imem_req=0 while in reset; imem_addr=RESET_PC.
  - if_pc=RESET_PC, if_instr=NOP_INSTR, if_valid=0.
- Reset mid-operation: any outstanding response is lost. The bench must not return rvalid for a pre-reset request.
- FSM states: REQ, WAIT, HOLD. Registered, one-hot or binary.
  - REQ: imem_req=1 and imem_addr=pc_q for exactly one cycle, then WAIT.
  - WAIT: imem_req=0. On imem_rvalid with kill=0, capture imem_rdata into the buffer with buf_pc=pc_q, then HOLD. On imem_rvalid with kill=1, discard the data, clear kill, then REQ.
  - HOLD: if_valid=1, if_pc=buf_pc, if_instr=buffer. If if_id_en=1, pc_q<=pc_q+4 and go to REQ. If if_id_en=0, stay in HOLD with outputs stable (stall).
- Latency: with a 1-cycle memory, request in cycle N, rvalid in N+1, if_valid in N+2, IF/ID latches at the end of N+2, next request in N+3. Peak throughput is 1 instruction per 3 cycles.
- PC arithmetic: 32-bit, +4 modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no error.
- Redirect has highest priority. When redirect_valid=1 in any state, pc_q<={redirect_pc[31:2],2'b00}.
  - REQ: the request issued this cycle is killed; set kill=1 and go to WAIT.
  - WAIT without rvalid: set kill=1 and stay in WAIT.
  - WAIT with rvalid the same cycle: discard the data and go to REQ with kill=0.
  - HOLD: drop the buffer and go to REQ.
  - In the redirect cycle, if_valid is forced combinationally to 0 and if_instr to NOP_INSTR. If if_id_en=1 that cycle, IF/ID therefore latches a bubble and never the wrong-path word.
- Redirect in the same cycle as an HOLD accept (if_id_en=1): redirect wins; pc_q takes the target, not pc+4.
- Back-to-back redirects: the last one wins. kill is a single flag; one outstanding request means at most one stale response.
- if_pc holds its last value while if_valid=0. Only if_instr is forced to NOP_INSTR.
- No combinational path from imem_rdata to any output. Only redirect_valid feeds if_valid/if_instr combinationally.

Decomposition:
- Shared package/defines: `ADDR_WIDTH, `DATA_WIDTH (existing), NOP_INSTR encoding, and the fetch FSM state encodings (so debug and trace logic can decode them).
- Sub-modules: pc_q, buf_pc and the instruction buffer are instances of the existing DFF_EN register cell with init values RESET_PC, RESET_PC and NOP_INSTR. No other sub-module.

Test Plan:
- Reset release, 1-cycle memory returning 32'h0010_0093 for addr 0: imem_req at cycle 0 with addr 0, if_valid=1 with if_pc=0 and if_instr=32'h0010_0093 at cycle 2, next req addr 4 at cycle 3.
- Stall: if_id_en=0 for 5 cycles in HOLD. Outputs are stable, imem_req=0 throughout, and the next request goes to addr+4 only after if_id_en=1.
- Redirect during WAIT to 32'h0000_0203, memory latency 3. The stale response is discarded (if_valid stays 0), then a request to 32'h0000_0200 is issued and its word is presented with if_pc=32'h200.
- Redirect in HOLD with if_id_en=1 the same cycle. if_valid=0 and if_instr=32'h0000_0013 in that cycle, and the next imem_addr is the target, not pc+4.
- Wrap: RESET_PC=32'hFFFF_FFFC. After the first accept, the next imem_addr=32'h0000_0000.
- Async reset asserted mid-WAIT. Outputs return to their reset values immediately without a clock edge, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage: bus widths, the bubble
// instruction encoding and the fetch FSM state encodings. Trace and debug logic
// can import this package to decode the fetch state.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package instr_fetch_pkg;

   // addi x0,x0,0 -- the canonical RISC-V nop used as a pipeline bubble
   localparam logic [`DATA_WIDTH-1:0] NOP_INSTR_ENC = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

   // Instruction addresses are always word aligned; the low two bits of any
   // externally supplied target are dropped.
   function automatic logic [`ADDR_WIDTH-1:0] align_pc(input logic [`ADDR_WIDTH-1:0] pc);
      return pc & ~`ADDR_WIDTH'(3);
   endfunction

endpackage

// File: rtl/DFF_EN.sv
// -----------------------------------------------------------------------------
// DFF_EN
// Generic register cell with load enable and asynchronous active-low reset to
// a parameterised initial value.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, loads INIT
//   en    - load enable; q takes d on a clock edge when en=1
//   d     - next value
//   q     - registered value
// -----------------------------------------------------------------------------
module DFF_EN #(
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= INIT;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage and producer side of the IF/ID pipeline register.
// Owns the PC, issues one outstanding request at a time to instruction memory,
// buffers each returned word together with its PC and presents it until the
// IF/ID register accepts it. Redirects from later stages override everything.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   imem_req, imem_addr        - single-cycle request strobe and word address
//   imem_rvalid, imem_rdata    - memory response (at least one cycle later)
//   if_id_en                   - IF/ID enable; 1 = downstream latches this cycle
//   redirect_valid, redirect_pc- branch/jump/trap redirect and its target
//   if_pc, if_instr, if_valid  - buffered instruction presented to IF/ID
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [`ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [`DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [`ADDR_WIDTH-1:0] imem_addr,
   input  logic                   imem_rvalid,
   input  logic [`DATA_WIDTH-1:0] imem_rdata,
   input  logic                   if_id_en,
   input  logic                   redirect_valid,
   input  logic [`ADDR_WIDTH-1:0] redirect_pc,
   output logic [`ADDR_WIDTH-1:0] if_pc,
   output logic [`DATA_WIDTH-1:0] if_instr,
   output logic                   if_valid
);

   fetch_state_e           state_q, state_d;
   logic                   kill_q, kill_d;
   logic                   pc_en, buf_en;
   logic [`ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [`ADDR_WIDTH-1:0] buf_pc_q;
   logic [`DATA_WIDTH-1:0] buf_q;

   DFF_EN #(.WIDTH(`ADDR_WIDTH), .INIT(RESET_PC)) u_pc (
      .clk(clk), .rst_n(rst_n), .en(pc_en), .d(pc_d), .q(pc_q)
   );

   DFF_EN #(.WIDTH(`ADDR_WIDTH), .INIT(RESET_PC)) u_buf_pc (
      .clk(clk), .rst_n(rst_n), .en(buf_en), .d(pc_q), .q(buf_pc_q)
   );

   DFF_EN #(.WIDTH(`DATA_WIDTH), .INIT(NOP_INSTR)) u_buf (
      .clk(clk), .rst_n(rst_n), .en(buf_en), .d(imem_rdata), .q(buf_q)
   );

   // Next-state logic. kill marks the single outstanding request as wrong-path
   // so its response is swallowed instead of buffered. A redirect always loads
   // the aligned target into the PC, even over an accept in HOLD.
   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      pc_en   = 1'b0;
      pc_d    = pc_q + `ADDR_WIDTH'(4);
      buf_en  = 1'b0;

      case (state_q)
         FETCH_REQ: begin
            state_d = FETCH_WAIT;
            if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         FETCH_WAIT: begin
            if (redirect_valid) begin
               if (imem_rvalid) begin
                  // the outstanding response is consumed right now, nothing left to kill
                  state_d = FETCH_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = FETCH_REQ;
               end else begin
                  buf_en  = 1'b1;
                  state_d = FETCH_HOLD;
               end
            end
         end
         FETCH_HOLD: begin
            if (redirect_valid) begin
               state_d = FETCH_REQ;
            end else if (if_id_en) begin
               pc_en   = 1'b1;
               state_d = FETCH_REQ;
            end
         end
         default: begin
            state_d = FETCH_REQ;
            kill_d  = 1'b0;
         end
      endcase

      if (redirect_valid) begin
         pc_en = 1'b1;
         pc_d  = align_pc(redirect_pc);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_REQ;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   // The state resets to REQ so the first request goes out in the very first
   // cycle after release; gating with rst_n keeps the strobe low during reset.
   assign imem_req  = (state_q == FETCH_REQ) && rst_n;
   assign imem_addr = pc_q;

   // Only redirect_valid reaches the IF/ID outputs combinationally, so a
   // wrong-path word can never be latched in the redirect cycle.
   assign if_valid = (state_q == FETCH_HOLD) && !redirect_valid;
   assign if_instr = if_valid ? buf_q : NOP_INSTR;
   assign if_pc    = buf_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A behavioural instruction memory with
// programmable latency answers requests; a PC model pushes the expected
// {pc, word} for every live request into a scoreboard queue and pops it when
// the IF/ID register accepts an instruction. A second instance with
// RESET_PC=32'hFFFF_FFFC watches PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_id_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   logic        wImemReq;
   logic [31:0] wImemAddr;
   logic [31:0] wIfPc;
   logic [31:0] wIfInstr;
   logic        wIfValid;

   int          testCount = 0;
   int          failCount = 0;
   int          acceptCount = 0;
   int          memLat = 1;
   int          pendCnt = 0;
   logic [31:0] pendAddr = 32'h0;
   logic [31:0] expPc = 32'h0;
   logic [63:0] sbQ[$];
   logic [31:0] savedPc;
   logic [31:0] savedInstr;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_en(if_id_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(wImemReq), .imem_addr(wImemAddr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_en(if_id_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_pc(wIfPc), .if_instr(wIfInstr), .if_valid(wIfValid)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: a fixed addi at address 0, a scrambled pattern elsewhere
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Behavioural memory, working on the falling edge: requests are sampled
   // mid-cycle and the response is raised memLat cycles later for one cycle.
   // Reset throws away anything in flight.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            pendCnt = 0;
         end else begin
            if (pendCnt > 0) begin
               pendCnt--;
               if (pendCnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = memWord(pendAddr);
               end
            end
            if (imem_req) begin
               pendCnt  = memLat;
               pendAddr = imem_addr;
            end
         end
      end
   end

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Per-cycle scoreboard/model update, run just after inputs settle
   task automatic monitor();
      logic [63:0] e;
      if (imem_req) begin
         checkOutput("req_addr", imem_addr, expPc);
         if (!redirect_valid) sbQ.push_back({expPc, memWord(expPc)});
      end
      if (!if_valid) checkOutput("bubble_nop", if_instr, NOP);
      if (redirect_valid) begin
         checkOutput("redir_valid", {31'b0, if_valid}, 32'd0);
         checkOutput("redir_nop", if_instr, NOP);
         sbQ.delete();
         expPc = {redirect_pc[31:2], 2'b00};
      end else if (if_valid && if_id_en) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_empty", 32'(sbQ.size()), 32'd1);
         end else begin
            e = sbQ.pop_front();
            checkOutput("acc_pc", if_pc, e[63:32]);
            checkOutput("acc_instr", if_instr, e[31:0]);
         end
         expPc = expPc + 32'd4;
         acceptCount++;
      end
   endtask

   // One cycle: drive inputs on the falling edge, sample 1 ns later
   task automatic applyStimulus(input logic en, input logic rv, input logic [31:0] rpc);
      @(negedge clk);
      if_id_en       = en;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      monitor();
   endtask

   task automatic waitValid(input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         if (if_valid) found = 1'b1;
      end
      checkOutput("wait_valid", {31'b0, if_valid}, 32'd1);
   endtask

   task automatic waitAccept(input int n, input int budget);
      int target = acceptCount + n;
      for (int i = 0; i < budget && acceptCount < target; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
      end
      checkOutput("wait_accept", 32'(acceptCount), 32'(target));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req"},   {31'b0, imem_req}, 32'd0);
      checkOutput({tag, "_addr"},  imem_addr, 32'h0);
      checkOutput({tag, "_pc"},    if_pc, 32'h0);
      checkOutput({tag, "_instr"}, if_instr, NOP);
      checkOutput({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      if_id_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Reset values, both instances
      repeat (3) @(negedge clk);
      #1;
      checkResetValues("rst");
      checkOutput("rst_wrap_addr", wImemAddr, 32'hFFFF_FFFC);

      // Release just after a rising edge; cycle 0 starts here
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Basic latency with a 1-cycle memory
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c0_req", {31'b0, imem_req}, 32'd1);
      checkOutput("c0_wrap_addr", wImemAddr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c1_valid", {31'b0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c2_valid", {31'b0, if_valid}, 32'd1);
      checkOutput("c2_pc", if_pc, 32'h0);
      checkOutput("c2_instr", if_instr, 32'h0010_0093);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("c3_req", {31'b0, imem_req}, 32'd1);
      checkOutput("c3_addr", imem_addr, 32'h4);
      checkOutput("wrap_next_addr", wImemAddr, 32'h0);

      // Stall in HOLD for 5 cycles
      waitValid(10);
      savedPc    = if_pc;
      savedInstr = if_instr;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("stall_valid", {31'b0, if_valid}, 32'd1);
         checkOutput("stall_pc", if_pc, savedPc);
         checkOutput("stall_instr", if_instr, savedInstr);
         checkOutput("stall_req", {31'b0, imem_req}, 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      memLat = 3;
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("stall_next_addr", imem_addr, savedPc + 32'd4);

      // Redirect while waiting on a 3-cycle memory: stale word must vanish
      applyStimulus(1'b0, 1'b1, 32'h0000_0203);
      waitValid(20);
      checkOutput("wait_redir_pc", if_pc, 32'h0000_0200);
      checkOutput("wait_redir_instr", if_instr, memWord(32'h0000_0200));
      applyStimulus(1'b1, 1'b0, 32'h0);
      memLat = 1;

      // Redirect in HOLD on the same cycle as an accept
      waitValid(10);
      applyStimulus(1'b1, 1'b1, 32'h0000_0401);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("hold_redir_req", {31'b0, imem_req}, 32'd1);
      checkOutput("hold_redir_addr", imem_addr, 32'h0000_0400);
      waitAccept(1, 10);

      // Redirect in the REQ cycle right after an accept
      applyStimulus(1'b0, 1'b1, 32'h0000_0300);
      waitAccept(1, 20);

      // Asynchronous reset in the middle of WAIT
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      checkResetValues("async_rst");
      sbQ.delete();
      expPc = 32'h0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      waitAccept(2, 20);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
